// File: rtl/hb_pkg.sv
// Shared definitions for the halfband decimator and later FIR stages.
// State encoding, width helpers and default coefficient set.
package hb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      RND,
      OUT
   } hb_state_e;

   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++)
         if ((32'sd1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic int nu(input int ntap);
      return (ntap + 1) / 4;
   endfunction

   function automatic int acc_w(input int dw,
                                input int cw,
                                input int ntap);
      return dw + 1 + cw + clog2(nu(ntap) + 1);
   endfunction

   // h0 in the low word, centre tap in the high word
   localparam logic [4*25-1:0] COEF_INIT_DEF = {
      25'h0008000,
      25'h0004BE4,
      25'h1FFF218,
      25'h0000209
   };

endpackage

// File: rtl/hb_round_sat.sv
// Round-half-up, arithmetic shift and saturate from an
// accumulator of AW bits down to an OW-bit sample.
module hb_round_sat #(
   parameter int AW   = 45,
   parameter int FRAC = 16,
   parameter int OW   = 18
) (
   input  logic signed [AW-1:0] acc_i,
   output logic signed [OW-1:0] sat_o
);

   localparam logic signed [AW:0] HALF =
      {{(AW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [AW:0] MAXV =
      {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [AW:0] MINV =
      {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

   logic signed [AW:0] sum_d;
   logic signed [AW:0] shr_d;

   always_comb begin
      sum_d = {acc_i[AW-1], acc_i} + HALF;
      shr_d = sum_d >>> FRAC;
      if (shr_d > MAXV)
         sat_o = MAXV[OW-1:0];
      else if (shr_d < MINV)
         sat_o = MINV[OW-1:0];
      else
         sat_o = shr_d[OW-1:0];
   end

endmodule

// File: rtl/hb_decim_mac.sv
// Multichannel halfband decimate-by-2 with one shared multiplier
// and a double-buffered run-time coefficient bank.
module hb_decim_mac
   import hb_pkg::*;
#(
   parameter int DW   = 17,
   parameter int OW   = 18,
   parameter int CW   = 25,
   parameter int FRAC = 16,
   parameter int NTAP = 11,
   parameter int NCH  = 4,
   parameter logic [((NTAP+1)/4+1)*CW-1:0] COEF_INIT = COEF_INIT_DEF
) (
   input  logic                        CICCLK,
   input  logic                        RST,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [clog2(NCH)-1:0]       in_ch,
   input  logic signed [DW-1:0]        in_data,
   output logic                        out_valid,
   output logic [clog2(NCH)-1:0]       out_ch,
   output logic signed [OW-1:0]        out_data,
   input  logic                        coef_we,
   input  logic [clog2(nu(NTAP)+1)-1:0] coef_addr,
   input  logic signed [CW-1:0]        coef_data,
   input  logic                        coef_commit,
   output logic                        drop,
   input  logic                        drop_clr
);

   localparam int NU  = nu(NTAP);
   localparam int CHW = clog2(NCH);
   localparam int CAW = clog2(NU + 1);
   localparam int AW  = acc_w(DW, CW, NTAP);
   localparam int PW  = DW + 1 + CW;

   logic signed [DW-1:0] line_q [NCH][NTAP];
   logic [NCH-1:0]       phase_q;
   logic signed [CW-1:0] shad_q [NU+1];
   logic signed [CW-1:0] act_q [NU+1];
   hb_state_e            st_q;
   logic [CAW-1:0]       cnt_q;
   logic [CHW-1:0]       ch_q;
   logic signed [AW-1:0] acc_q;
   logic signed [OW-1:0] res_q;
   logic signed [OW-1:0] out_data_q;
   logic [CHW-1:0]       out_ch_q;
   logic                 out_valid_q;
   logic                 drop_q;
   logic                 pend_q;

   logic                 busy;
   logic                 accept;
   logic                 start;
   logic signed [DW-1:0] tap_a;
   logic signed [DW-1:0] tap_b;
   logic signed [DW:0]   pre_d;
   logic signed [PW-1:0] prod_d;
   logic signed [AW-1:0] acc_d;
   logic signed [OW-1:0] sat_d;

   assign busy      = (st_q == MAC) || (st_q == RND);
   assign in_ready  = ~busy;
   assign accept    = in_valid & ~busy;
   assign start     = accept & ~phase_q[in_ch];
   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign out_data  = out_data_q;
   assign drop      = drop_q;

   // Symmetric tap pair for this MAC step; the last step is the centre tap.
   always_comb begin
      tap_a = '0;
      tap_b = '0;
      for (int k = 0; k < NU; k++)
         if (cnt_q == CAW'(k)) begin
            tap_a = line_q[ch_q][2*k];
            tap_b = line_q[ch_q][NTAP-1-2*k];
         end
      if (cnt_q == CAW'(NU))
         tap_a = line_q[ch_q][(NTAP-1)/2];
      pre_d  = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
      prod_d = pre_d * act_q[cnt_q];
      acc_d  = acc_q + AW'(prod_d);
   end

   hb_round_sat #(
      .AW   (AW),
      .FRAC (FRAC),
      .OW   (OW)
   ) u_rnd (
      .acc_i (acc_q),
      .sat_o (sat_d)
   );

   always_ff @(posedge CICCLK or posedge RST) begin
      if (RST) begin
         for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NTAP; t++)
               line_q[c][t] <= '0;
         for (int i = 0; i <= NU; i++) begin
            shad_q[i] <= COEF_INIT[i*CW +: CW];
            act_q[i]  <= COEF_INIT[i*CW +: CW];
         end
         phase_q     <= '0;
         st_q        <= IDLE;
         cnt_q       <= '0;
         ch_q        <= '0;
         acc_q       <= '0;
         res_q       <= '0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         drop_q      <= 1'b0;
         pend_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept) begin
            phase_q[in_ch]   <= ~phase_q[in_ch];
            line_q[in_ch][0] <= in_data;
            for (int t = 1; t < NTAP; t++)
               line_q[in_ch][t] <= line_q[in_ch][t-1];
         end
         if (in_valid && busy)
            drop_q <= 1'b1;
         else if (drop_clr)
            drop_q <= 1'b0;
         if (coef_we)
            shad_q[coef_addr] <= coef_data;
         // Commits wait for the end of a compute so a result never mixes banks.
         if (busy) begin
            if (coef_commit) pend_q <= 1'b1;
         end else if (coef_commit || pend_q) begin
            act_q  <= shad_q;
            pend_q <= 1'b0;
         end
         unique case (st_q)
            MAC: begin
               acc_q <= acc_d;
               if (cnt_q == CAW'(NU))
                  st_q <= RND;
               else
                  cnt_q <= cnt_q + CAW'(1);
            end
            RND: begin
               res_q <= sat_d;
               st_q  <= OUT;
            end
            default: begin
               if (st_q == OUT) begin
                  out_valid_q <= 1'b1;
                  out_ch_q    <= ch_q;
                  out_data_q  <= res_q;
               end
               if (start) begin
                  st_q  <= MAC;
                  cnt_q <= '0;
                  acc_q <= '0;
                  ch_q  <= in_ch;
               end else begin
                  st_q <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hb_decim_mac.sv
// Directed plus random bench for hb_decim_mac against a
// full-convolution reference model of the decimating halfband.
module tb_hb_decim_mac;

   localparam int DW   = 17;
   localparam int OW   = 18;
   localparam int CW   = 25;
   localparam int NTAP = 11;
   localparam int NCH  = 4;
   localparam int NU   = 3;
   localparam int LAT  = NU + 3;
   localparam int BUSY = NU + 2;

   logic                 CICCLK = 1'b0;
   logic                 RST;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           in_ch;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic [1:0]           out_ch;
   logic signed [OW-1:0] out_data;
   logic                 coef_we;
   logic [1:0]           coef_addr;
   logic signed [CW-1:0] coef_data;
   logic                 coef_commit;
   logic                 drop;
   logic                 drop_clr;

   always #5 CICCLK = ~CICCLK;

   hb_decim_mac dut (
      .CICCLK      (CICCLK),
      .RST         (RST),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ch       (in_ch),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ch      (out_ch),
      .out_data    (out_data),
      .coef_we     (coef_we),
      .coef_addr   (coef_addr),
      .coef_data   (coef_data),
      .coef_commit (coef_commit),
      .drop        (drop),
      .drop_clr    (drop_clr)
   );

   typedef struct {
      int due;
      int ch;
      int val;
   } exp_t;

   exp_t   expq[$];
   int     got[$];
   int     gotch[$];
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     busy = 0;
   int     pend = 0;
   int     drop_m = 0;
   int     drops_seen = 0;
   int     last_out = 0;
   int     hist [NCH][NTAP];
   int     ph [NCH];
   longint act [NU+1];
   longint shad [NU+1];
   longint init_c [NU+1] = '{521, -3560, 19428, 32768};
   int     imp_exp [7] = '{261, -1780, 9714, 9714, -1780, 261, 0};
   int     dcv [NCH] = '{1000, 2000, -3000, 0};
   int     lastv [NCH];

   task automatic chk(string tag,
                      logic signed [63:0] obs,
                      logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   // Output is the rounded, saturated dot product of the full
   // 11-tap impulse response with the channel history.
   function automatic int ref_out(int c);
      longint h [NTAP];
      longint y;
      for (int n = 0; n < NTAP; n++) h[n] = 0;
      for (int k = 0; k < NU; k++) begin
         h[2*k]        = act[k];
         h[NTAP-1-2*k] = act[k];
      end
      h[(NTAP-1)/2] = act[NU];
      y = 0;
      for (int n = 0; n < NTAP; n++)
         y += h[n] * longint'(hist[c][n]);
      y = (y + 32768) >>> 16;
      if (y > 131071) y = 131071;
      if (y < -131072) y = -131072;
      return int'(y);
   endfunction

   task automatic model_reset();
      expq.delete();
      busy = 0;
      pend = 0;
      drop_m = 0;
      last_out = 0;
      for (int c = 0; c < NCH; c++) begin
         ph[c] = 0;
         for (int t = 0; t < NTAP; t++) hist[c][t] = 0;
      end
      for (int k = 0; k <= NU; k++) begin
         act[k]  = init_c[k];
         shad[k] = init_c[k];
      end
   endtask

   task automatic model_edge(bit rdy);
      exp_t e;
      bit   acc;
      acc = in_valid && rdy;
      if (in_valid && !rdy) drop_m = 1;
      else if (drop_clr) drop_m = 0;
      if (rdy && (coef_commit || pend != 0)) begin
         act  = shad;
         pend = 0;
      end else if (coef_commit) begin
         pend = 1;
      end
      if (coef_we) shad[coef_addr] = longint'(coef_data);
      if (busy > 0) busy--;
      if (acc) begin
         for (int t = NTAP - 1; t > 0; t--)
            hist[in_ch][t] = hist[in_ch][t-1];
         hist[in_ch][0] = int'(in_data);
         if (ph[in_ch] == 0) begin
            e.due = cyc + LAT;
            e.ch  = int'(in_ch);
            e.val = ref_out(int'(in_ch));
            expq.push_back(e);
            busy = BUSY;
         end
         ph[in_ch] ^= 1;
      end
   endtask

   task automatic check_outputs();
      if (expq.size() > 0 && expq[0].due == cyc) begin
         chk("out_valid", out_valid, 1);
         chk("out_ch", out_ch, expq[0].ch);
         chk("out_data", out_data, expq[0].val);
         last_out = expq[0].val;
         got.push_back(int'(out_data));
         gotch.push_back(int'(out_ch));
         void'(expq.pop_front());
      end else begin
         chk("out_valid_idle", out_valid, 0);
         chk("out_data_hold", out_data, last_out);
      end
      chk("drop", drop, drop_m);
   endtask

   task automatic tick();
      bit rdy;
      rdy = (busy == 0);
      chk("in_ready", in_ready, rdy);
      if (in_valid && !in_ready) drops_seen++;
      @(posedge CICCLK);
      cyc++;
      model_edge(rdy);
      #1;
      check_outputs();
      in_valid    = 1'b0;
      coef_we     = 1'b0;
      coef_commit = 1'b0;
      drop_clr    = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(int c, int val);
      for (int i = 0; i < 2 * LAT && busy != 0; i++) tick();
      in_valid = 1'b1;
      in_ch    = 2'(c);
      in_data  = DW'(val);
      tick();
   endtask

   task automatic flush(int c);
      if (ph[c] != 0) send(c, 0);
      for (int i = 0; i < 12; i++) send(c, 0);
      idle(LAT + 2);
      got.delete();
      gotch.delete();
   endtask

   task automatic impulse(int val, bit odd);
      flush(0);
      if (odd) send(0, 0);
      send(0, val);
      for (int i = (odd ? 2 : 1); i < 16; i++) send(0, 0);
      idle(LAT + 2);
   endtask

   task automatic do_reset();
      in_valid    = 1'b0;
      coef_we     = 1'b0;
      coef_commit = 1'b0;
      drop_clr    = 1'b0;
      RST = 1'b1;
      #1;
      model_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_drop", drop, 0);
      @(posedge CICCLK);
      #1;
      RST = 1'b0;
   endtask

   task automatic check_first_impulse();
      impulse(32768, 1'b0);
      chk("imp_count", got.size(), 8);
      for (int i = 0; i < 7; i++)
         chk($sformatf("imp[%0d]", i), got[i], imp_exp[i]);
   endtask

   initial begin
      in_valid    = 1'b0;
      in_ch       = '0;
      in_data     = '0;
      coef_we     = 1'b0;
      coef_addr   = '0;
      coef_data   = '0;
      coef_commit = 1'b0;
      drop_clr    = 1'b0;
      RST         = 1'b0;
      #2;
      do_reset();
      idle(3);

      check_first_impulse();

      impulse(32768, 1'b1);
      for (int i = 0; i < got.size(); i++)
         chk($sformatf("odd[%0d]", i), got[i],
             (i == 3) ? 16384 : 0);

      flush(0);
      for (int i = 0; i < 14; i++) send(0, 10000);
      idle(LAT + 2);
      chk("dc_steady", got[got.size()-1], 10002);

      for (int c = 0; c < NCH; c++) flush(c);
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < NCH; c++) send(c, dcv[c]);
      idle(LAT + 2);
      for (int c = 0; c < NCH; c++) lastv[c] = 12345;
      for (int i = 0; i < got.size(); i++) lastv[gotch[i]] = got[i];
      for (int c = 0; c < NCH; c++)
         chk($sformatf("dc_ch%0d", c), lastv[c], dcv[c]);

      flush(0);
      drops_seen = 0;
      for (int i = 0; i < BUSY + 1; i++) begin
         in_valid = 1'b1;
         in_ch    = 2'd0;
         in_data  = DW'(1234);
         tick();
      end
      chk("drops_seen", drops_seen, BUSY);
      chk("drop_set", drop, 1);
      drop_clr = 1'b1;
      tick();
      chk("drop_clr", drop, 0);

      for (int k = 0; k <= NU; k++) begin
         coef_we   = 1'b1;
         coef_addr = 2'(k);
         coef_data = (k == NU) ? CW'(32'h30000) : '0;
         tick();
      end
      flush(0);
      send(0, 5000);
      tick();
      coef_commit = 1'b1;
      tick();
      idle(LAT + 2);
      chk("old_bank", got[0], 40);

      impulse(65535, 1'b1);
      chk("sat_pos", got[3], 131071);
      impulse(-65536, 1'b1);
      chk("sat_neg", got[3], -131072);

      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 2) != 0);
         in_ch    = 2'($urandom_range(0, 3));
         in_data  = DW'($urandom);
         drop_clr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) begin
            coef_we   = 1'b1;
            coef_addr = 2'($urandom_range(0, 3));
            coef_data = CW'(int'($urandom_range(0, 65535)) - 32768);
         end
         coef_commit = ($urandom_range(0, 15) == 0);
         tick();
      end
      idle(LAT + 2);

      flush(0);
      send(0, 32768);
      tick();
      tick();
      do_reset();
      idle(10);
      check_first_impulse();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
